asg_dac_slew: RTL and testbench

Output conditioning stage placed directly downstream of one ASG channel: consumes the channel's 14-bit signed DAC code every `dac_clk_i` cycle and drives the DAC pins. It provides soft start/stop ramps between a programmable park level and the live waveform, plus a per-cycle slew-rate limit while tracking, so enabling or disabling a channel never produces a full-scale step. It also counts how many cycles the limiter was active, for software diagnostics.

---
 rtl/asg_dac_slew.sv | 119 +++++++++++
 tb/tb_asg_dac_slew.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asg_dac_slew.sv
// rtl/asg_dac_slew.sv - DAC output conditioning: soft park/enable ramps and tracking slew limiter
module asg_dac_slew #(
  parameter int DW = 14,
  parameter int CW = 32
) (
  input  logic                 dac_clk_i,
  input  logic                 dac_rst_i,
  input  logic signed [DW-1:0] dat_i,
  input  logic                 set_en_i,
  input  logic signed [DW-1:0] set_park_i,
  input  logic        [DW-1:0] set_ramp_i,
  input  logic        [DW-1:0] set_slew_i,
  input  logic                 set_clr_i,
  output logic signed [DW-1:0] dat_o,
  output logic        [1:0]    state_o,
  output logic                 ramp_done_o,
  output logic        [CW-1:0] lim_cnt_o
);

  typedef enum logic [1:0] {
    PARKED  = 2'd0,
    RAMP_UP = 2'd1,
    TRACK   = 2'd2,
    RAMP_DN = 2'd3
  } state_t;

  state_t          state;
  logic [DW-1:0]   target;
  logic [DW-1:0]   lim;
  logic [DW:0]     cur_ext;
  logic [DW:0]     tgt_ext;
  logic [DW:0]     lim_ext;
  logic [DW:0]     diff;
  logic [DW:0]     diff_abs;
  logic [DW:0]     step_sum;
  logic            reached;
  logic [DW-1:0]   next_out;

  // PARKED uses a zero limit so the park level is applied unconditionally.
  always_comb begin
    target = set_park_i;
    lim    = '0;
    case (state)
      RAMP_UP: begin
        target = dat_i;
        lim    = set_ramp_i;
      end
      TRACK: begin
        target = dat_i;
        lim    = set_slew_i;
      end
      RAMP_DN: begin
        target = set_park_i;
        lim    = set_ramp_i;
      end
      default: begin
        target = set_park_i;
        lim    = '0;
      end
    endcase
  end

  // One extra bit holds any difference of two DW-bit codes without overflow.
  assign cur_ext  = {dat_o[DW-1], dat_o};
  assign tgt_ext  = {target[DW-1], target};
  assign lim_ext  = {1'b0, lim};
  assign diff     = tgt_ext - cur_ext;
  assign diff_abs = diff[DW] ? (~diff + 1'b1) : diff;
  assign reached  = (lim == '0) || (diff_abs <= lim_ext);
  assign step_sum = diff[DW] ? (cur_ext - lim_ext) : (cur_ext + lim_ext);
  assign next_out = reached ? target : step_sum[DW-1:0];

  assign state_o = state;

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state       <= PARKED;
      dat_o       <= '0;
      ramp_done_o <= 1'b0;
      lim_cnt_o   <= '0;
    end else begin
      dat_o       <= next_out;
      ramp_done_o <= 1'b0;
      case (state)
        PARKED: begin
          if (set_en_i) state <= RAMP_UP;
        end
        RAMP_UP: begin
          if (!set_en_i) begin
            state <= RAMP_DN;
          end else if (reached) begin
            state       <= TRACK;
            ramp_done_o <= 1'b1;
          end
        end
        TRACK: begin
          if (!set_en_i) state <= RAMP_DN;
        end
        RAMP_DN: begin
          if (set_en_i) begin
            state <= RAMP_UP;
          end else if (reached) begin
            state       <= PARKED;
            ramp_done_o <= 1'b1;
          end
        end
        default: state <= PARKED;
      endcase

      // Clear wins over a coincident increment; the counter sticks at all-ones.
      if (set_clr_i) begin
        lim_cnt_o <= '0;
      end else if ((state == TRACK) && !reached && (lim_cnt_o != '1)) begin
        lim_cnt_o <= lim_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_asg_dac_slew.sv
// tb/tb_asg_dac_slew.sv - randomized and directed bench for asg_dac_slew against a behavioural model
module tb_asg_dac_slew;
  localparam int DW = 14;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] dat_i = '0;
  logic                 en = 1'b0;
  logic signed [DW-1:0] park = '0;
  logic        [DW-1:0] ramp = '0;
  logic        [DW-1:0] slew = '0;
  logic                 clr = 1'b0;
  logic signed [DW-1:0] dat_o;
  logic        [1:0]    state_o;
  logic                 ramp_done_o;
  logic        [CW-1:0] lim_cnt_o;

  int m_out, m_state, m_done, m_cnt;
  int n_vec = 0;
  int n_err = 0;

  asg_dac_slew #(.DW(DW), .CW(CW)) dut (
    .dac_clk_i  (clk),
    .dac_rst_i  (rst),
    .dat_i      (dat_i),
    .set_en_i   (en),
    .set_park_i (park),
    .set_ramp_i (ramp),
    .set_slew_i (slew),
    .set_clr_i  (clr),
    .dat_o      (dat_o),
    .state_o    (state_o),
    .ramp_done_o(ramp_done_o),
    .lim_cnt_o  (lim_cnt_o)
  );

  always #5 clk = ~clk;

  // Model: each edge the current mode picks a target and step limit, the output
  // moves toward the target by at most that limit, and the mode follows enable.
  task automatic tick();
    int tgt, lim, d, ad, nstate, ndone;
    bit reached;
    @(posedge clk);
    if (rst) begin
      m_out = 0; m_state = 0; m_done = 0; m_cnt = 0;
    end else begin
      if (m_state == 0)      begin tgt = int'(park);  lim = 0; end
      else if (m_state == 1) begin tgt = int'(dat_i); lim = int'(ramp); end
      else if (m_state == 2) begin tgt = int'(dat_i); lim = int'(slew); end
      else                   begin tgt = int'(park);  lim = int'(ramp); end
      d = tgt - m_out;
      ad = (d < 0) ? -d : d;
      reached = (lim == 0) || (ad <= lim);
      nstate = m_state;
      ndone = 0;
      case (m_state)
        0: if (en) nstate = 1;
        1: if (!en) nstate = 3; else if (reached) begin nstate = 2; ndone = 1; end
        2: if (!en) nstate = 3;
        default: if (en) nstate = 1; else if (reached) begin nstate = 0; ndone = 1; end
      endcase
      if (clr) m_cnt = 0;
      else if (m_state == 2 && !reached && m_cnt < CMAX) m_cnt = m_cnt + 1;
      m_out = reached ? tgt : ((d > 0) ? m_out + lim : m_out - lim);
      m_state = nstate;
      m_done = ndone;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; park = -14'sd100; en = 1'b0;
    tick();
    n_vec++;
    if (int'(dat_o) !== 0 || state_o !== 2'd0 || ramp_done_o !== 1'b0 || lim_cnt_o !== '0) begin
      n_err++;
      $display("FAIL reset: dat_o=%0d state=%0d done=%0d cnt=%0d, want 0 0 0 0", dat_o, state_o, ramp_done_o, lim_cnt_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (int'(dat_o) !== -100 || state_o !== 2'd0) begin
        n_err++;
        $display("FAIL park_level[%0d]: dat_o=%0d state=%0d, want -100 0", i, dat_o, state_o);
      end
    end
  endtask

  task automatic test_ramp_up();
    int dones = 0;
    park = '0; ramp = 14'd1000; dat_i = 14'sd5000;
    tick();
    en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (int'(dat_o) !== 1000 * (i + 1) || int'(dat_o) !== m_out || int'(state_o) !== m_state) begin
        n_err++;
        $display("FAIL ramp_up[%0d]: dat_o=%0d state=%0d, want %0d %0d", i, dat_o, state_o, 1000 * (i + 1), m_state);
      end
      dones += int'(ramp_done_o);
    end
    tick();
    dones += int'(ramp_done_o);
    n_vec++;
    if (state_o !== 2'd2 || dones !== 1) begin
      n_err++;
      $display("FAIL ramp_up_done: state=%0d pulses=%0d, want 2 1", state_o, dones);
    end
  endtask

  task automatic test_slew();
    int c0;
    int exp_out[3] = '{5100, 5200, 5250};
    c0 = int'(lim_cnt_o);
    slew = 14'd100; dat_i = 14'sd5250;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (int'(dat_o) !== exp_out[i] || int'(dat_o) !== m_out) begin
        n_err++;
        $display("FAIL slew[%0d]: dat_o=%0d, want %0d", i, dat_o, exp_out[i]);
      end
    end
    n_vec++;
    if (int'(lim_cnt_o) !== c0 + 2 || int'(lim_cnt_o) !== m_cnt) begin
      n_err++;
      $display("FAIL slew_cnt: cnt=%0d, want %0d", lim_cnt_o, c0 + 2);
    end
  endtask

  task automatic test_slew_bypass();
    int c0;
    c0 = int'(lim_cnt_o);
    slew = '0; dat_i = 14'sd5000;
    tick();
    dat_i = 14'sd5250;
    tick();
    n_vec++;
    if (int'(dat_o) !== 5250 || int'(lim_cnt_o) !== c0) begin
      n_err++;
      $display("FAIL slew_bypass: dat_o=%0d cnt=%0d, want 5250 %0d", dat_o, lim_cnt_o, c0);
    end
  endtask

  task automatic test_reversal();
    int dones = 0;
    dat_i = 14'sd3000; park = '0; ramp = 14'd1000;
    tick();
    en = 1'b0;
    tick();
    tick();
    n_vec++;
    if (int'(dat_o) !== 2000 || state_o !== 2'd3) begin
      n_err++;
      $display("FAIL reversal_dn: dat_o=%0d state=%0d, want 2000 3", dat_o, state_o);
    end
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      dones += int'(ramp_done_o);
      n_vec++;
      if (int'(dat_o) !== m_out || int'(state_o) !== m_state || int'(ramp_done_o) !== m_done) begin
        n_err++;
        $display("FAIL reversal[%0d]: dat_o=%0d state=%0d done=%0d, want %0d %0d %0d",
                 i, dat_o, state_o, ramp_done_o, m_out, m_state, m_done);
      end
    end
    n_vec++;
    if (dones !== 1 || state_o !== 2'd2 || int'(dat_o) !== 3000) begin
      n_err++;
      $display("FAIL reversal_done: pulses=%0d state=%0d dat_o=%0d, want 1 2 3000", dones, state_o, dat_o);
    end
  endtask

  task automatic test_saturation();
    slew = 14'd1;
    for (int i = 0; i < 300; i++) begin
      dat_i = (i % 2 == 1) ? 14'sd8000 : -14'sd8000;
      tick();
    end
    n_vec++;
    if (int'(lim_cnt_o) !== CMAX || m_cnt !== CMAX) begin
      n_err++;
      $display("FAIL saturation: cnt=%0d, want %0d", lim_cnt_o, CMAX);
    end
  endtask

  task automatic test_clr_coincide();
    dat_i = 14'sd8000; clr = 1'b1;
    tick();
    clr = 1'b0;
    n_vec++;
    if (lim_cnt_o !== '0) begin
      n_err++;
      $display("FAIL clr_coincide: cnt=%0d, want 0", lim_cnt_o);
    end
    tick();
    n_vec++;
    if (int'(lim_cnt_o) !== 1) begin
      n_err++;
      $display("FAIL clr_restart: cnt=%0d, want 1", lim_cnt_o);
    end
  endtask

  task automatic test_extremes();
    park = 14'sd8191; en = 1'b0; ramp = 14'd16383; slew = '0;
    for (int i = 0; i < 3; i++) tick();
    n_vec++;
    if (int'(dat_o) !== 8191 || state_o !== 2'd0) begin
      n_err++;
      $display("FAIL extreme_park: dat_o=%0d state=%0d, want 8191 0", dat_o, state_o);
    end
    en = 1'b1; dat_i = -14'sd8192;
    tick();
    tick();
    n_vec++;
    if (int'(dat_o) !== -8192 || state_o !== 2'd2 || ramp_done_o !== 1'b1) begin
      n_err++;
      $display("FAIL extreme_step: dat_o=%0d state=%0d done=%0d, want -8192 2 1", dat_o, state_o, ramp_done_o);
    end
  endtask

  task automatic test_ramp_small();
    int prev;
    dat_i = 14'sd8191;
    tick();
    en = 1'b0; park = '0; ramp = 14'd10;
    tick();
    prev = int'(dat_o);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (int'(dat_o) !== prev - 10 || int'(dat_o) !== m_out) begin
        n_err++;
        $display("FAIL ramp_small[%0d]: dat_o=%0d, want %0d", i, dat_o, prev - 10);
      end
      prev = prev - 10;
    end
    ramp = 14'd16383;
    tick();
    tick();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 11) == 0) en = ~en;
      clr = ($urandom_range(0, 49) == 0);
      r = $urandom_range(0, 3);
      if (r == 0)      dat_i = DW'($urandom_range(0, 16383));
      else if (r == 1) dat_i = DW'(int'(dat_i) + $urandom_range(0, 60) - 30);
      if ($urandom_range(0, 99) == 0) park = DW'($urandom_range(0, 16383));
      if ($urandom_range(0, 79) == 0) begin
        r = $urandom_range(0, 3);
        ramp = (r == 0) ? '0 : (r == 1) ? DW'($urandom_range(0, 16383)) : DW'($urandom_range(1, 400));
      end
      if ($urandom_range(0, 79) == 0) begin
        r = $urandom_range(0, 2);
        slew = (r == 0) ? '0 : DW'($urandom_range(1, 50));
      end
      tick();
      n_vec++;
      if (int'(dat_o) !== m_out || int'(state_o) !== m_state ||
          int'(ramp_done_o) !== m_done || int'(lim_cnt_o) !== m_cnt) begin
        n_err++;
        $display("FAIL random[%0d]: dat_o=%0d state=%0d done=%0d cnt=%0d, want %0d %0d %0d %0d",
                 i, dat_o, state_o, ramp_done_o, lim_cnt_o, m_out, m_state, m_done, m_cnt);
      end
    end
    rst = 1'b0; clr = 1'b0;
  endtask

  initial begin
    m_out = 0; m_state = 0; m_done = 0; m_cnt = 0;
    test_reset();
    test_ramp_up();
    test_slew();
    test_slew_bypass();
    test_reversal();
    test_saturation();
    test_clr_coincide();
    test_extremes();
    test_ramp_small();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
